// File: rtl/mod_csr_unit.sv
// Machine-mode CSR unit: atomic CSR read-modify-write port, trap/mret sequencing,
// trap-vector generation, interrupt-pending evaluation and 64-bit counters.

module mod_csr_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter bit              COUNTERS_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            csr_src_nz_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            instr_retire_i,
    input  logic            timer_irq_i,
    input  logic            ext_irq_i,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending_o
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] A_MVENDORID     = 12'hF11;
    localparam logic [11:0] A_MARCHID       = 12'hF12;
    localparam logic [11:0] A_MIMPID        = 12'hF13;
    localparam logic [11:0] A_MHARTID       = 12'hF14;
    localparam logic [11:0] A_MSTATUS       = 12'h300;
    localparam logic [11:0] A_MISA          = 12'h301;
    localparam logic [11:0] A_MIE           = 12'h304;
    localparam logic [11:0] A_MTVEC         = 12'h305;
    localparam logic [11:0] A_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] A_MEPC          = 12'h341;
    localparam logic [11:0] A_MCAUSE        = 12'h342;
    localparam logic [11:0] A_MTVAL         = 12'h343;
    localparam logic [11:0] A_MIP           = 12'h344;
    localparam logic [11:0] A_MCYCLE        = 12'hB00;
    localparam logic [11:0] A_MINSTRET      = 12'hB02;
    localparam logic [11:0] A_MCYCLEH       = 12'hB80;
    localparam logic [11:0] A_MINSTRETH     = 12'hB82;

    localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(2'b11);
    localparam bit              HAS_HI     = (XLEN == 32);

    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic            mtip_q;
    logic            meip_q;
    logic            cy_inh_q;
    logic            ir_inh_q;
    logic [63:0]     mcycle_q;
    logic [63:0]     minstret_q;

    logic [XLEN-1:0] mip_vec;
    logic [XLEN-1:0] csr_val;
    logic            csr_impl;
    logic [XLEN-1:0] wval;
    logic            wr_req;
    logic            illegal;
    logic            csr_we;

    always_comb begin
        mip_vec     = '0;
        mip_vec[7]  = mtip_q;
        mip_vec[11] = meip_q;
    end

    always_comb begin
        csr_val  = '0;
        csr_impl = 1'b1;
        case (csr_addr_i)
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MISA: csr_val = '0;
            A_MHARTID:  csr_val = HART_ID;
            A_MSTATUS: begin
                csr_val[3] = mstatus_mie_q;
                csr_val[7] = mstatus_mpie_q;
            end
            A_MIE:      csr_val = mie_q;
            A_MTVEC:    csr_val = mtvec_q;
            A_MEPC:     csr_val = mepc_q;
            A_MCAUSE:   csr_val = mcause_q;
            A_MTVAL:    csr_val = mtval_q;
            A_MIP:      csr_val = mip_vec;
            A_MCOUNTINHIBIT: begin
                csr_val[0] = COUNTERS_EN & cy_inh_q;
                csr_val[2] = COUNTERS_EN & ir_inh_q;
            end
            A_MCYCLE:   if (COUNTERS_EN) csr_val = mcycle_q[XLEN-1:0];
            A_MINSTRET: if (COUNTERS_EN) csr_val = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (!HAS_HI)          csr_impl = 1'b0;
                else if (COUNTERS_EN) csr_val  = XLEN'(mcycle_q[63:32]);
            end
            A_MINSTRETH: begin
                if (!HAS_HI)          csr_impl = 1'b0;
                else if (COUNTERS_EN) csr_val  = XLEN'(minstret_q[63:32]);
            end
            default:    csr_impl = 1'b0;
        endcase
    end

    // Read-modify-write value is built from the pre-edge CSR contents.
    always_comb begin
        case (csr_op_i)
            OP_RS:   wval = csr_val | csr_wdata_i;
            OP_RC:   wval = csr_val & ~csr_wdata_i;
            default: wval = csr_wdata_i;
        endcase
    end

    assign wr_req      = (csr_op_i != OP_NONE) && ((csr_op_i == OP_RW) || csr_src_nz_i);
    assign illegal     = (csr_op_i != OP_NONE) &&
                         (!csr_impl || (wr_req && (csr_addr_i[11:10] == 2'b11)));
    assign csr_we      = wr_req && !illegal;
    assign illegal_o   = illegal;
    assign csr_rdata_o = (csr_op_i != OP_NONE) ? csr_val : '0;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval;
    logic wr_mcountinhibit, wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    assign wr_mstatus       = csr_we && (csr_addr_i == A_MSTATUS);
    assign wr_mie           = csr_we && (csr_addr_i == A_MIE);
    assign wr_mtvec         = csr_we && (csr_addr_i == A_MTVEC);
    assign wr_mepc          = csr_we && (csr_addr_i == A_MEPC);
    assign wr_mcause        = csr_we && (csr_addr_i == A_MCAUSE);
    assign wr_mtval         = csr_we && (csr_addr_i == A_MTVAL);
    assign wr_mcountinhibit = csr_we && (csr_addr_i == A_MCOUNTINHIBIT);
    assign wr_mcycle        = csr_we && (csr_addr_i == A_MCYCLE);
    assign wr_minstret      = csr_we && (csr_addr_i == A_MINSTRET);
    assign wr_mcycleh       = csr_we && HAS_HI && (csr_addr_i == A_MCYCLEH);
    assign wr_minstreth     = csr_we && HAS_HI && (csr_addr_i == A_MINSTRETH);

    // Trap wins over mret, which wins over a CSR write to the same fields.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mtip_q         <= 1'b0;
            meip_q         <= 1'b0;
        end else begin
            if (trap_i) begin
                mepc_q         <= trap_pc_i & ALIGN_MASK;
                mcause_q       <= trap_cause_i;
                mtval_q        <= trap_tval_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else begin
                if (mret_i) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end else if (wr_mstatus) begin
                    mstatus_mie_q  <= wval[3];
                    mstatus_mpie_q <= wval[7];
                end
                if (wr_mepc)   mepc_q   <= wval & ALIGN_MASK;
                if (wr_mcause) mcause_q <= wval;
                if (wr_mtval)  mtval_q  <= wval;
            end
            if (wr_mie)   mie_q   <= wval & MIE_MASK;
            if (wr_mtvec) mtvec_q <= {wval[XLEN-1:2], 1'b0, (wval[1:0] == 2'b01)};
            mtip_q <= timer_irq_i;
            meip_q <= ext_irq_i;
        end
    end

    // A written counter half is replaced and the whole counter skips its increment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else if (COUNTERS_EN) begin
            if (wr_mcountinhibit) begin
                cy_inh_q <= wval[0];
                ir_inh_q <= wval[2];
            end
            if (wr_mcycle) begin
                if (HAS_HI) mcycle_q[31:0] <= wval[31:0];
                else        mcycle_q       <= 64'(wval);
            end else if (wr_mcycleh) begin
                mcycle_q[63:32] <= wval[31:0];
            end else if (!cy_inh_q) begin
                mcycle_q <= mcycle_q + 64'd1;
            end
            if (wr_minstret) begin
                if (HAS_HI) minstret_q[31:0] <= wval[31:0];
                else        minstret_q       <= 64'(wval);
            end else if (wr_minstreth) begin
                minstret_q[63:32] <= wval[31:0];
            end else if (instr_retire_i && !ir_inh_q) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    always_comb begin
        trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00};
        if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[XLEN-1])
            trap_vector_o = trap_vector_o + (trap_cause_i << 2);
    end

    assign mepc_o        = mepc_q;
    assign irq_pending_o = mstatus_mie_q & (|(mie_q & mip_vec));

endmodule

// File: tb/tb_mod_csr_unit.sv
// Bench for mod_csr_unit: directed scenarios plus randomized traffic checked
// against a behavioural CSR model.

module tb_mod_csr_unit;

    localparam logic [31:0] HART = 32'h0000_0003;
    localparam logic [31:0] MTR  = 32'h1000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        src_nz;
    logic [31:0] rdata;
    logic        illegal;
    logic        trap;
    logic [31:0] cause, tpc, tval;
    logic        mret, retire, tirq, eirq;
    logic [31:0] tvec, mepc;
    logic        irqp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mod_csr_unit #(
        .XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTR), .COUNTERS_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .csr_addr_i(addr), .csr_op_i(op),
        .csr_wdata_i(wdata), .csr_src_nz_i(src_nz), .csr_rdata_o(rdata),
        .illegal_o(illegal), .trap_i(trap), .trap_cause_i(cause),
        .trap_pc_i(tpc), .trap_tval_i(tval), .mret_i(mret),
        .instr_retire_i(retire), .timer_irq_i(tirq), .ext_irq_i(eirq),
        .trap_vector_o(tvec), .mepc_o(mepc), .irq_pending_o(irqp)
    );

    // Behavioural model of the architectural CSR state.
    logic        m_mie_b, m_mpie, m_mtip, m_meip;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_cinh;
    logic [63:0] m_cycle, m_instret;

    function automatic logic [31:0] m_read(input logic [11:0] a, output logic impl);
        impl = 1'b1;
        case (a)
            12'hF11, 12'hF12, 12'hF13, 12'h301: m_read = 32'h0;
            12'hF14: m_read = HART;
            12'h300: m_read = (m_mie_b ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: m_read = m_mie;
            12'h305: m_read = m_mtvec;
            12'h341: m_read = m_mepc;
            12'h342: m_read = m_mcause;
            12'h343: m_read = m_mtval;
            12'h344: m_read = (m_mtip ? 32'h80 : 32'h0) | (m_meip ? 32'h800 : 32'h0);
            12'h320: m_read = m_cinh;
            12'hB00: m_read = m_cycle[31:0];
            12'hB80: m_read = m_cycle[63:32];
            12'hB02: m_read = m_instret[31:0];
            12'hB82: m_read = m_instret[63:32];
            default: begin m_read = 32'h0; impl = 1'b0; end
        endcase
    endfunction

    function automatic logic m_wr();
        return (op != 2'b00) && (op == 2'b01 || src_nz);
    endfunction

    function automatic logic exp_ill();
        logic impl;
        void'(m_read(addr, impl));
        return (op != 2'b00) && (!impl || (m_wr() && addr[11:10] == 2'b11));
    endfunction

    function automatic logic [31:0] exp_rd();
        logic impl;
        logic [31:0] v;
        v = m_read(addr, impl);
        return (op != 2'b00) ? v : 32'h0;
    endfunction

    function automatic logic [31:0] exp_tvec();
        logic [31:0] v;
        v = {m_mtvec[31:2], 2'b00};
        if (m_mtvec[1:0] == 2'b01 && cause[31]) v = v + cause[30:0] * 32'd4;
        return v;
    endfunction

    function automatic logic exp_irq();
        return m_mie_b && ((m_mie[7] && m_mtip) || (m_mie[11] && m_meip));
    endfunction

    task automatic m_step();
        logic        impl, we, old_mie;
        logic [31:0] old, nv, cinh_old;
        logic [63:0] cyc_n, ir_n;
        if (!rst_n) begin
            m_mie_b = 0; m_mpie = 0; m_mtip = 0; m_meip = 0;
            m_mie = 0; m_mtvec = MTR; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cinh = 0; m_cycle = 0; m_instret = 0;
            return;
        end
        old = m_read(addr, impl);
        we  = m_wr() && !exp_ill();
        nv  = (op == 2'b01) ? wdata : (op == 2'b10) ? (old | wdata) : (old & ~wdata);
        old_mie  = m_mie_b;
        cinh_old = m_cinh;
        cyc_n = cinh_old[0] ? m_cycle : m_cycle + 64'd1;
        ir_n  = (retire && !cinh_old[2]) ? m_instret + 64'd1 : m_instret;
        if (we) begin
            case (addr)
                12'h300: if (!trap && !mret) begin m_mie_b = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie = nv & 32'h888;
                12'h305: m_mtvec = {nv[31:2], 2'b00} | {31'b0, nv[1:0] == 2'b01};
                12'h341: if (!trap) m_mepc = {nv[31:2], 2'b00};
                12'h342: if (!trap) m_mcause = nv;
                12'h343: if (!trap) m_mtval = nv;
                12'h320: m_cinh = nv & 32'h5;
                12'hB00: cyc_n = {m_cycle[63:32], nv};
                12'hB80: cyc_n = {nv, m_cycle[31:0]};
                12'hB02: ir_n  = {m_instret[63:32], nv};
                12'hB82: ir_n  = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        if (trap) begin
            m_mepc = {tpc[31:2], 2'b00}; m_mcause = cause; m_mtval = tval;
            m_mpie = old_mie; m_mie_b = 1'b0;
        end else if (mret) begin
            m_mie_b = m_mpie; m_mpie = 1'b1;
        end
        m_cycle = cyc_n; m_instret = ir_n;
        m_mtip = tirq; m_meip = eirq;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        op = 2'b00; src_nz = 1'b0; wdata = 32'h0; trap = 1'b0; mret = 1'b0; retire = 1'b0;
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [1:0] o,
                           input logic [31:0] d, input logic nz);
        addr = a; op = o; wdata = d; src_nz = nz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); addr = 12'h0;
        tick(); tick();
        rst_n = 1'b1; #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        vectors++; if (irqp !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irqp); end
        vectors++; if (mepc !== 32'h0) begin miscompares++; $display("FAIL reset_mepc: got %h want 0", mepc); end
        vectors++; if (tvec !== 32'h1000_0000) begin miscompares++; $display("FAIL reset_tvec: got %h want 10000000", tvec); end
        set_csr(12'h305, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== MTR) begin miscompares++; $display("FAIL reset_mtvec: got %h want %h", rdata, MTR); end
        set_csr(12'hB00, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_mcycle: got %h want 0", rdata); end
        tick(); idle();
    endtask

    task automatic test_mtvec_vector();
        set_csr(12'h305, 2'b01, 32'h8000_0101, 1'b1); #1;
        vectors++; if (rdata !== MTR) begin miscompares++; $display("FAIL mtvec_old: got %h want %h", rdata, MTR); end
        tick();
        set_csr(12'h305, 2'b10, 32'h0, 1'b0);
        trap = 1'b1; cause = 32'h8000_0007; tpc = 32'h1234_5677; tval = 32'h0000_DEAD; #1;
        vectors++; if (rdata !== 32'h8000_0101) begin miscompares++; $display("FAIL mtvec_rd: got %h want 80000101", rdata); end
        vectors++; if (tvec !== 32'h8000_011C) begin miscompares++; $display("FAIL tvec_vectored: got %h want 8000011c", tvec); end
        tick(); trap = 1'b0;
        set_csr(12'h342, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (mepc !== 32'h1234_5674) begin miscompares++; $display("FAIL trap_mepc: got %h want 12345674", mepc); end
        vectors++; if (rdata !== 32'h8000_0007) begin miscompares++; $display("FAIL trap_mcause: got %h want 80000007", rdata); end
        set_csr(12'h343, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h0000_DEAD) begin miscompares++; $display("FAIL trap_mtval: got %h want 0000dead", rdata); end
        tick(); idle();
    endtask

    task automatic test_mstatus();
        set_csr(12'h300, 2'b10, 32'h8, 1'b1); #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL mstatus_old: got %h want 0", rdata); end
        tick();
        set_csr(12'h300, 2'b10, 32'h80, 1'b0); #1;
        vectors++; if (rdata !== 32'h8) begin miscompares++; $display("FAIL mstatus_rs: got %h want 8", rdata); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL mstatus_ill: got %b want 0", illegal); end
        tick(); #1;
        vectors++; if (rdata !== 32'h8) begin miscompares++; $display("FAIL mstatus_nz0: got %h want 8", rdata); end
        set_csr(12'hF14, 2'b01, 32'h5, 1'b1); #1;
        vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL mhartid_wr_ill: got %b want 1", illegal); end
        tick();
        set_csr(12'hF14, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL mhartid_rd_ill: got %b want 0", illegal); end
        vectors++; if (rdata !== HART) begin miscompares++; $display("FAIL mhartid_rd: got %h want %h", rdata, HART); end
        set_csr(12'h7C0, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL unimpl_ill: got %b want 1", illegal); end
        op = 2'b00; #1;
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL unimpl_noop: got %b want 0", illegal); end
        tick(); idle();
    endtask

    task automatic test_irq();
        set_csr(12'h304, 2'b01, 32'hFFFF_FFFF, 1'b1); tick();
        set_csr(12'h304, 2'b11, 32'h0000_0808, 1'b1); #1;
        vectors++; if (rdata !== 32'h888) begin miscompares++; $display("FAIL mie_mask: got %h want 888", rdata); end
        tick();
        set_csr(12'h304, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h80) begin miscompares++; $display("FAIL mie_rc: got %h want 80", rdata); end
        idle(); tirq = 1'b1; #1;
        vectors++; if (irqp !== 1'b0) begin miscompares++; $display("FAIL irq_latency: got %b want 0", irqp); end
        tick(); #1;
        vectors++; if (irqp !== 1'b1) begin miscompares++; $display("FAIL irq_pending: got %b want 1", irqp); end
        set_csr(12'h344, 2'b01, 32'h0, 1'b1); #1;
        vectors++; if (illegal !== 1'b0 || rdata !== 32'h80) begin miscompares++; $display("FAIL mip_wr: got ill=%b rd=%h want ill=0 rd=80", illegal, rdata); end
        tick();
        set_csr(12'h344, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h80) begin miscompares++; $display("FAIL mip_ro: got %h want 80", rdata); end
        trap = 1'b1; cause = 32'h0000_000B; tpc = 32'h0000_0200; #1;
        vectors++; if (tvec !== 32'h8000_0100) begin miscompares++; $display("FAIL tvec_exc: got %h want 80000100", tvec); end
        tick(); trap = 1'b0;
        set_csr(12'h300, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h80 || irqp !== 1'b0) begin miscompares++; $display("FAIL trap_mstatus: got %h irq=%b want 80 irq=0", rdata, irqp); end
        vectors++; if (mepc !== 32'h200) begin miscompares++; $display("FAIL mret_target: got %h want 200", mepc); end
        mret = 1'b1; tick(); mret = 1'b0; #1;
        vectors++; if (rdata !== 32'h88 || irqp !== 1'b1) begin miscompares++; $display("FAIL mret_mstatus: got %h irq=%b want 88 irq=1", rdata, irqp); end
        tirq = 1'b0; tick(); idle();
    endtask

    task automatic test_priority();
        trap = 1'b1; mret = 1'b1; cause = 32'h8000_0003; tpc = 32'hABCD_0003;
        set_csr(12'h300, 2'b01, 32'h8, 1'b1); #1;
        vectors++; if (tvec !== 32'h8000_010C) begin miscompares++; $display("FAIL prio_tvec: got %h want 8000010c", tvec); end
        tick(); idle();
        set_csr(12'h300, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h80) begin miscompares++; $display("FAIL prio_mstatus: got %h want 80", rdata); end
        vectors++; if (mepc !== 32'hABCD_0000) begin miscompares++; $display("FAIL prio_mepc: got %h want abcd0000", mepc); end
        trap = 1'b1; cause = 32'h2; tpc = 32'h0000_4446;
        set_csr(12'h341, 2'b01, 32'h5550, 1'b1); tick(); idle(); #1;
        vectors++; if (mepc !== 32'h4444) begin miscompares++; $display("FAIL trap_over_mepc: got %h want 4444", mepc); end
        trap = 1'b1; cause = 32'h8000_0005;
        set_csr(12'h305, 2'b01, 32'h2000_0003, 1'b1); #1;
        vectors++; if (tvec !== 32'h8000_0114) begin miscompares++; $display("FAIL tvec_pre: got %h want 80000114", tvec); end
        tick(); idle();
        set_csr(12'h305, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h2000_0000 || tvec !== 32'h2000_0000) begin miscompares++; $display("FAIL mtvec_with_trap: got rd=%h tv=%h want 20000000", rdata, tvec); end
        tick(); idle();
    endtask

    task automatic test_counters();
        set_csr(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b1); tick();
        set_csr(12'hB80, 2'b01, 32'h0, 1'b1); tick();
        set_csr(12'hB80, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL mcycleh_wr: got %h want 0", rdata); end
        addr = 12'hB00; #1;
        vectors++; if (rdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mcycle_hold: got %h want ffffffff", rdata); end
        tick(); #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL mcycle_wrap: got %h want 0", rdata); end
        addr = 12'hB80; #1;
        vectors++; if (rdata !== 32'h1) begin miscompares++; $display("FAIL mcycleh_carry: got %h want 1", rdata); end
        set_csr(12'hB02, 2'b01, 32'hFFFF_FFFF, 1'b1); tick();
        set_csr(12'hB82, 2'b01, 32'h77, 1'b1); retire = 1'b1; tick();
        set_csr(12'hB82, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h77) begin miscompares++; $display("FAIL minstreth_wr: got %h want 77", rdata); end
        addr = 12'hB02; #1;
        vectors++; if (rdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL minstret_hold: got %h want ffffffff", rdata); end
        tick(); #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL minstret_wrap: got %h want 0", rdata); end
        addr = 12'hB82; #1;
        vectors++; if (rdata !== 32'h78) begin miscompares++; $display("FAIL minstreth_carry: got %h want 78", rdata); end
        idle();
    endtask

    task automatic test_inhibit_reset();
        set_csr(12'h320, 2'b01, 32'hFFFF_FFFF, 1'b1); tick();
        set_csr(12'h320, 2'b10, 32'h0, 1'b0); retire = 1'b1; #1;
        vectors++; if (rdata !== 32'h5) begin miscompares++; $display("FAIL mcountinhibit: got %h want 5", rdata); end
        for (int i = 0; i < 3; i++) tick();
        addr = 12'hB00; #1;
        vectors++; if (rdata !== m_cycle[31:0]) begin miscompares++; $display("FAIL mcycle_frozen: got %h want %h", rdata, m_cycle[31:0]); end
        addr = 12'hB02; #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL minstret_frozen: got %h want 0", rdata); end
        set_csr(12'h320, 2'b01, 32'h0, 1'b1); tick();
        idle(); tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_csr(12'hB00, 2'b10, 32'h0, 1'b0); #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mcycle: got %h want 0", rdata); end
        addr = 12'hB82; #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_minstreth: got %h want 0", rdata); end
        addr = 12'h305; #1;
        vectors++; if (rdata !== MTR) begin miscompares++; $display("FAIL rst_mtvec: got %h want %h", rdata, MTR); end
        tick(); idle();
    endtask

    task automatic test_random();
        logic [11:0] alist [17] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301,
                                    12'h304, 12'h305, 12'h320, 12'h341, 12'h342, 12'h343,
                                    12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82};
        for (int n = 0; n < 600; n++) begin
            addr   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : alist[$urandom_range(0, 16)];
            op     = 2'($urandom);
            wdata  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            src_nz = 1'($urandom);
            trap   = ($urandom_range(0, 7) == 0);
            mret   = ($urandom_range(0, 7) == 0);
            cause  = $urandom; tpc = $urandom; tval = $urandom;
            retire = 1'($urandom); tirq = 1'($urandom); eirq = 1'($urandom);
            rst_n  = ($urandom_range(0, 99) != 0);
            #1;
            vectors++; if (rdata !== exp_rd()) begin miscompares++; $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", n, addr, rdata, exp_rd()); end
            vectors++; if (illegal !== exp_ill()) begin miscompares++; $display("FAIL rnd_illegal[%0d] a=%h: got %b want %b", n, addr, illegal, exp_ill()); end
            vectors++; if (tvec !== exp_tvec()) begin miscompares++; $display("FAIL rnd_tvec[%0d]: got %h want %h", n, tvec, exp_tvec()); end
            vectors++; if (mepc !== m_mepc) begin miscompares++; $display("FAIL rnd_mepc[%0d]: got %h want %h", n, mepc, m_mepc); end
            vectors++; if (irqp !== exp_irq()) begin miscompares++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irqp, exp_irq()); end
            tick();
        end
        rst_n = 1'b1; idle(); tirq = 1'b0; eirq = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; idle(); addr = 12'h0;
        cause = 32'h0; tpc = 32'h0; tval = 32'h0; tirq = 1'b0; eirq = 1'b0;
        @(negedge clk);
        test_reset();
        test_mtvec_vector();
        test_mstatus();
        test_irq();
        test_priority();
        test_counters();
        test_inhibit_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
